// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD seven-segment converter.
// Latency: none (types, constants and an elaboration-time helper only).
// Backpressure: not applicable.
package bcd_pkg;

    // Converter control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Segments a..g driven by the hex decoder.
    localparam int SEG_W = 7;

    // Active-low display: all ones turns every segment off.
    localparam logic [SEG_W-1:0] SEG_BLANK = '1;

    // A nibble at or above this value gets +3 before the next shift, so the
    // shift carries into the next decimal digit instead of leaving 10..15.
    localparam logic [3:0] ADD3_MIN = 4'd5;

    // True when DIGITS decimal digits can hold every IN-bit unsigned value,
    // i.e. 10^digits >= 2^in_w.
    function automatic bit bcd_fits(input int in_w, input int digits);
        longint unsigned p10;
        p10 = 1;
        for (int i = 0; i < digits; i++) begin
            p10 = p10 * 10;
        end
        return p10 >= (64'd1 << in_w);
    endfunction

endpackage

// File: rtl/decoder_0_F.sv
// Hex digit to active-low seven-segment pattern.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   hex  4-bit value 0..F
//   seg  segment drive, seg[0] = a ... seg[6] = g, 0 lights a segment
module decoder_0_F (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Patterns are written in a..g reading order (leftmost = a) and then
    // reversed so that bit 0 carries segment a.
    logic [6:0] abcdefg;

    always_comb begin
        abcdefg = 7'b1111111;
        case (hex)
            4'h0: abcdefg = 7'b0000001;
            4'h1: abcdefg = 7'b1001111;
            4'h2: abcdefg = 7'b0010010;
            4'h3: abcdefg = 7'b0000110;
            4'h4: abcdefg = 7'b1001100;
            4'h5: abcdefg = 7'b0100100;
            4'h6: abcdefg = 7'b0100000;
            4'h7: abcdefg = 7'b0001111;
            4'h8: abcdefg = 7'b0000000;
            4'h9: abcdefg = 7'b0000100;
            4'hA: abcdefg = 7'b0001000;
            4'hB: abcdefg = 7'b1100000;
            4'hC: abcdefg = 7'b0110001;
            4'hD: abcdefg = 7'b1000010;
            4'hE: abcdefg = 7'b0110000;
            4'hF: abcdefg = 7'b0111000;
            default: abcdefg = 7'b1111111;
        endcase
    end

    always_comb begin
        seg = '1;
        for (int i = 0; i < 7; i++) begin
            seg[i] = abcdefg[6-i];
        end
    end

endmodule

// File: rtl/bin_to_bcd_seg.sv
// Sequential double-dabble binary-to-BCD converter with seven-segment outputs.
// Latency: start at edge t -> done pulse in the cycle after edge t+IN+1.
// Backpressure: none; start is only accepted in IDLE, requests while busy are dropped.
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   start        conversion request (sampled in IDLE only)
//   bin_in       unsigned binary value, captured with start
//   blank_lz     leading-zero blanking enable, captured with start
//   busy         high from the accepting edge through the done cycle
//   done         one-cycle pulse, results valid
//   bcd_out      packed BCD, digit k in bits 4k+3..4k
//   seg_out      active-low segments, digit k in bits S*k+S-1..S*k, segment a lowest
module bin_to_bcd_seg
    import bcd_pkg::*;
#(
    parameter int IN     = 10,
    parameter int DIGITS = 4,
    parameter int S      = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [IN-1:0]       bin_in,
    input  logic                blank_lz,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic [S*DIGITS-1:0] seg_out
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(IN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN - 1);

    // Parameter sanity: refuse to build a converter that cannot represent
    // its full input range or drive a complete a..g display.
    if (!bcd_fits(IN, DIGITS)) begin : g_range_err
        $error("bin_to_bcd_seg: DIGITS too small for IN-bit input");
    end
    if (IN < 4) begin : g_in_err
        $error("bin_to_bcd_seg: IN must be at least 4");
    end
    if (S < SEG_W) begin : g_seg_err
        $error("bin_to_bcd_seg: S must be at least 7");
    end

    state_t           state;
    logic [IN-1:0]    bin_sh;
    logic [BCD_W-1:0] bcd_sh;
    logic [CNT_W-1:0] cnt;
    logic             blank_q;

    logic [BCD_W-1:0]    bcd_adj;
    logic [BCD_W-1:0]    bcd_nxt;
    logic [DIGITS-1:0]   blank_dig;
    logic [S*DIGITS-1:0] seg_nxt;

    // One double-dabble step: correct every nibble, then shift in the next
    // binary bit MSB first.
    always_comb begin
        bcd_adj = bcd_sh;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_sh[4*k +: 4] >= ADD3_MIN) begin
                bcd_adj[4*k +: 4] = bcd_sh[4*k +: 4] + 4'd3;
            end
        end
        bcd_nxt = {bcd_adj[BCD_W-2:0], bin_sh[IN-1]};
    end

    // A digit is blanked only if it and every digit above it are zero.
    // Scanning from the top keeps a running "still leading zeros" flag;
    // the units digit always displays so a zero result reads "0".
    always_comb begin
        logic run;
        run       = blank_q;
        blank_dig = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            run          = run && (bcd_nxt[4*k +: 4] == 4'd0);
            blank_dig[k] = run;
        end
    end

    // Decoders look at the step's result so the registered outputs can be
    // loaded on the same edge that enters DONE.
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        logic [SEG_W-1:0] dec_seg;
        logic [S-1:0]     seg_dig;

        decoder_0_F u_dec (
            .hex (bcd_nxt[4*k +: 4]),
            .seg (dec_seg)
        );

        // Segments beyond a..g (if S > 7) are held dark.
        always_comb begin
            seg_dig = '1;
            seg_dig[SEG_W-1:0] = blank_dig[k] ? SEG_BLANK : dec_seg;
        end

        assign seg_nxt[S*k +: S] = seg_dig;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd_out <= '0;
            seg_out <= '1;
            bin_sh  <= '0;
            bcd_sh  <= '0;
            cnt     <= '0;
            blank_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        bin_sh  <= bin_in;
                        blank_q <= blank_lz;
                        bcd_sh  <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= ST_SHIFT;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    bcd_sh <= bcd_nxt;
                    bin_sh <= {bin_sh[IN-2:0], 1'b0};
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state   <= ST_DONE;
                        bcd_out <= bcd_nxt;
                        seg_out <= seg_nxt;
                    end
                end
                ST_DONE: begin
                    // busy stays high through the following done cycle;
                    // IDLE clears it unless a new start arrives there.
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/bin_to_bcd_seg.md
BIN_TO_BCD_SEG -- requirements
Module: bin_to_bcd_seg

Interface
REQ-001 The block SHALL have parameter IN, default 10, binary input width (>=4).
REQ-002 The block SHALL have parameter DIGITS, default 4, number of decimal digits/displays.
REQ-003 The block SHALL have parameter S, default 7, segments per display.
REQ-004 Elaboration SHALL fail if 10^DIGITS < 2^IN.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 start  input  1  conversion request, sampled only in IDLE.
REQ-008 bin_in  input  IN  unsigned binary value, captured with start.
REQ-009 blank_lz  input  1  leading-zero blanking enable, captured with start.
REQ-010 busy  output  1  high while a conversion is in progress.
REQ-011 done  output  1  one-cycle pulse when new results are valid.
REQ-012 bcd_out  output  4*DIGITS  packed BCD result, digit k in bits 4k+3..4k (k=0 units).
REQ-013 seg_out  output  S*DIGITS  displays, digit k in bits S*k..S*k+S-1, lowest index = segment a, active-low.

Function
REQ-014 Conversion SHALL use sequential double-dabble: per shift cycle, add 3 to every scratch nibble >=5, then shift left one bit, inserting the next captured bit, MSB first.
REQ-015 FSM states SHALL be IDLE, SHIFT, DONE: IDLE->SHIFT on start; SHIFT->DONE after exactly IN shifts; DONE->IDLE unconditionally.
REQ-016 On start in IDLE, bin_in and blank_lz SHALL be captured, scratch cleared, shift counter zeroed.
REQ-017 Latency: start high at edge t SHALL produce done high during the cycle after edge t+IN+1; busy high from edge t through the cycle done is high.
REQ-018 bcd_out and seg_out SHALL be registered, updated only on entry to DONE, and held unchanged otherwise.
REQ-019 start while busy (SHIFT or DONE) SHALL be ignored; no queuing.
REQ-020 Changes on bin_in/blank_lz after capture SHALL NOT affect the running conversion.
REQ-021 Each BCD digit SHALL be 0..9; seg encoding a..g: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
REQ-022 With captured blank_lz=1, every zero digit above the most-significant non-zero digit SHALL show 1111111; digit 0 SHALL never be blanked.
REQ-023 bcd_out SHALL not be affected by blank_lz.
REQ-024 Back-to-back: start held high continuously SHALL begin a new conversion in the cycle after DONE (every IN+2 cycles).

Reset
REQ-025 rst_n low at a clock edge SHALL force IDLE, busy=0, done=0, bcd_out=0, seg_out all ones (blank), scratch/counter cleared.
REQ-026 Reset mid-conversion SHALL abort without a done pulse and without updating outputs beyond their reset values.

Structure
REQ-027 Shared package bcd_pkg SHALL hold the state enumeration, SEG_BLANK constant (all ones) and add-3 threshold constant.
REQ-028 Digit-to-segment mapping SHALL reuse the existing decoder_0_F module, instantiated DIGITS times by generate, with a blanking mux after it.

Verification
REQ-029 bin_in=63, blank_lz=0, start one cycle -> done after IN+1 cycles, bcd_out=0x0063, seg digits 3..0 = 0000001,0000001,0100000,0000110.
REQ-030 bin_in=63, blank_lz=1 -> bcd_out=0x0063, digits 3,2 = 1111111, digits 1,0 = 0100000,0000110.
REQ-031 bin_in=1023 -> bcd_out=0x1023, done exactly 11 cycles after start edge; bin_in=0, blank_lz=1 -> digit 0 = 0000001, others 1111111.
REQ-032 start pulsed again 3 cycles into a 500 conversion with bin_in=7 -> ignored, result 0x0500, single done pulse.
REQ-033 rst_n low 5 cycles into conversion -> busy=0, no done, bcd_out=0, seg_out all ones; next start converts correctly.
REQ-034 start held high with bin_in=999 -> done pulses every 12 cycles, bcd_out=0x0999 each time.
